// File: rtl/chacha_stream_xor.sv
// ChaCha20 stream XOR engine: builds the block state, runs one block core,
// XORs 16 buffered keystream words onto a 32-bit valid/ready stream.
// Ports: clk, rst_n, start, key, nonce, ctr_init, in_* (sink), out_* (source),
// busy (not IDLE), done (pulse after last word), err_ctr_wrap (sticky).

module chacha_block #(
  parameter int BLK_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [511:0] state_in,
  output logic [511:0] state_out
);

  function automatic logic [127:0] qr(
    input logic [31:0] a, input logic [31:0] b,
    input logic [31:0] c, input logic [31:0] d
  );
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  logic [31:0]  s [16];
  logic [31:0]  x [16];
  logic [511:0] res;
  logic [511:0] pipe [BLK_LAT];

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      s[i] = state_in[511-32*i -: 32];
      x[i] = s[i];
    end
    for (int r = 0; r < 10; r++) begin
      {x[0], x[4], x[8],  x[12]} = qr(x[0], x[4], x[8],  x[12]);
      {x[1], x[5], x[9],  x[13]} = qr(x[1], x[5], x[9],  x[13]);
      {x[2], x[6], x[10], x[14]} = qr(x[2], x[6], x[10], x[14]);
      {x[3], x[7], x[11], x[15]} = qr(x[3], x[7], x[11], x[15]);
      {x[0], x[5], x[10], x[15]} = qr(x[0], x[5], x[10], x[15]);
      {x[1], x[6], x[11], x[12]} = qr(x[1], x[6], x[11], x[12]);
      {x[2], x[7], x[8],  x[13]} = qr(x[2], x[7], x[8],  x[13]);
      {x[3], x[4], x[9],  x[14]} = qr(x[3], x[4], x[9],  x[14]);
    end
    res = '0;
    for (int i = 0; i < 16; i++)
      res[511-32*i -: 32] = x[i] + s[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BLK_LAT; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= res;
      for (int i = 1; i < BLK_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign state_out = pipe[BLK_LAT-1];

endmodule

module chacha_stream_xor #(
  parameter int BLK_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [255:0] key,
  input  logic [95:0]  nonce,
  input  logic [31:0]  ctr_init,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [31:0]  out_data,
  output logic         out_last,
  output logic         busy,
  output logic         done,
  output logic         err_ctr_wrap
);

  localparam logic [127:0] SIGMA =
    128'h61707865_3320646e_79622d32_6b206574;
  localparam int LW = $clog2(BLK_LAT + 2);

  typedef enum logic [1:0] {IDLE, GEN, STREAM, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [255:0]  key_r;
  logic [95:0]   nonce_r;
  logic [31:0]   ctr;
  logic [511:0]  state_in_r;
  logic [511:0]  core_out;
  logic [511:0]  ks_buf;
  logic [3:0]    word_idx;
  logic [LW-1:0] lat_cnt;
  logic          acc;
  logic          gen_done;
  logic          blk_end;
  logic [8:0]    ks_lsb;
  logic [31:0]   ctr_nx;

  chacha_block #(.BLK_LAT(BLK_LAT)) u_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .state_in  (state_in_r),
    .state_out (core_out)
  );

  assign gen_done = (state_q == GEN) && (lat_cnt == LW'(BLK_LAT));
  assign acc      = in_valid & in_ready;
  assign blk_end  = acc & ~in_last & (word_idx == 4'd15);
  // word n sits at bit (15-n)*32; ~word_idx == 15-word_idx
  assign ks_lsb   = {~word_idx, 5'b0};
  assign ctr_nx   = ctr + 32'd1;
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:   if (start) state_d = GEN;
      GEN:    if (gen_done) state_d = STREAM;
      STREAM: begin
        in_ready = ~out_valid | out_ready;
        if (in_valid & in_ready) begin
          if (in_last)                state_d = DRAIN;
          else if (word_idx == 4'd15) state_d = GEN;
        end
      end
      DRAIN:  if (out_valid & out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_r        <= '0;
      nonce_r      <= '0;
      ctr          <= '0;
      state_in_r   <= '0;
      ks_buf       <= '0;
      word_idx     <= '0;
      lat_cnt      <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      done         <= 1'b0;
      err_ctr_wrap <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q == IDLE && start) begin
        key_r        <= key;
        nonce_r      <= nonce;
        ctr          <= ctr_init;
        state_in_r   <= {SIGMA, key, ctr_init, nonce};
        lat_cnt      <= '0;
        err_ctr_wrap <= 1'b0;
      end
      if (state_q == GEN) begin
        if (gen_done) begin
          ks_buf   <= core_out;
          word_idx <= '0;
        end else begin
          lat_cnt <= lat_cnt + LW'(1);
        end
      end
      if (acc) begin
        out_data  <= in_data ^ ks_buf[ks_lsb +: 32];
        out_last  <= in_last;
        out_valid <= 1'b1;
        word_idx  <= word_idx + 4'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (blk_end) begin
        ctr        <= ctr_nx;
        state_in_r <= {SIGMA, key_r, ctr_nx, nonce_r};
        lat_cnt    <= '0;
        if (ctr == 32'hffff_ffff) err_ctr_wrap <= 1'b1;
      end
      if (state_q == DRAIN && out_valid && out_ready) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chacha_stream_xor.sv
// Directed bench for chacha_stream_xor: RFC vector, round trip, stalls,
// counter wrap, async reset and ignored start.

module tb_chacha_stream_xor;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] key;
  logic [95:0]  nonce;
  logic [31:0]  ctr_init;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         busy;
  logic         done;
  logic         err_ctr_wrap;

  chacha_stream_xor #(.BLK_LAT(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .key          (key),
    .nonce        (nonce),
    .ctr_init     (ctr_init),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .err_ctr_wrap (err_ctr_wrap)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int bubbles;

  logic [31:0]  msg[$];
  logic [31:0]  got[$];
  logic [31:0]  orig[$];
  logic [255:0] key_main, key_alt;
  logic [95:0]  nonce_main;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Reference block function from the algorithm description
  function automatic logic [31:0] ks_word(input logic [255:0] k,
      input logic [31:0] c, input logic [95:0] n, input int w);
    logic [31:0] s[16];
    logic [31:0] x[16];
    int a, b, cc, d;
    s[0] = 32'h61707865; s[1] = 32'h3320646e;
    s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[255-32*i -: 32];
    s[12] = c;
    s[13] = n[95:64]; s[14] = n[63:32]; s[15] = n[31:0];
    x = s;
    for (int r = 0; r < 20; r++) begin
      for (int q = 0; q < 4; q++) begin
        a = q;
        if (r % 2 == 0) begin
          b = 4 + q; cc = 8 + q; d = 12 + q;
        end else begin
          b = 4 + (q + 1) % 4; cc = 8 + (q + 2) % 4; d = 12 + (q + 3) % 4;
        end
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 16);
        x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 12);
        x[a] = x[a] + x[b]; x[d] = rotl(x[d] ^ x[a], 8);
        x[cc] = x[cc] + x[d]; x[b] = rotl(x[b] ^ x[cc], 7);
      end
    end
    return x[w] + s[w];
  endfunction

  task automatic do_start(input logic [255:0] k, input logic [95:0] n,
                          input logic [31:0] c);
    key = k; nonce = n; ctr_init = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Feed msg[0..n-1]; collect outputs. Optional stall and stray start.
  task automatic run_stream(input int n, input bit last,
      input int stall_at, input int stall_len, input int start_at);
    int sent = 0, rcvd = 0, cyc = 0, stall_left = 0, stall_k = 0;
    bit first_acc = 0, stalled = 0, started = 0;
    logic [31:0] held = '0;
    got.delete();
    bubbles = 0;
    while ((sent < n || rcvd < n) && cyc < 2000) begin
      in_valid = (sent < n);
      in_data  = (sent < n) ? msg[sent] : 32'h0;
      in_last  = last && (sent == n - 1);
      if (!stalled && sent == stall_at) begin
        stalled = 1; stall_left = stall_len; stall_k = 0;
      end
      out_ready = (stall_left == 0);
      if (!started && sent == start_at) begin
        started = 1; start = 1'b1; key = key_alt;
      end
      @(negedge clk);
      if (start) chk("busy_on_stray_start", 32'(busy), 32'd1);
      if (stall_left > 0 && out_valid) begin
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        if (stall_k > 0) chk("stall_out_data", out_data, held);
        held = out_data;
        stall_k++;
      end
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        rcvd++;
      end
      if (in_valid && in_ready) begin
        sent++; first_acc = 1;
      end else if (first_acc && sent < n && out_ready) begin
        bubbles++;
      end
      if (stall_left > 0) stall_left--;
      @(posedge clk); #1;
      start = 1'b0; key = key_main;
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    chk("stream_complete", 32'(sent + rcvd), 32'(2 * n));
  endtask

  task automatic check_msg(input string tag, input logic [31:0] c0);
    chk({tag, "_count"}, 32'(got.size()), 32'(msg.size()));
    for (int i = 0; i < msg.size() && i < got.size(); i++)
      chk(tag, got[i],
          msg[i] ^ ks_word(key_main, c0 + 32'(i / 16), nonce_main, i % 16));
  endtask

  task automatic check_done();
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd1);
    chk("idle_after_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("done_clears", 32'(done), 32'd0);
    @(posedge clk); #1;
  endtask

  logic [31:0] rfc[4];

  initial begin
    rfc = '{32'he4e7f110, 32'h15593bd1, 32'h1fdd0f50, 32'hc47120a3};
    key_main = 256'h03020100_07060504_0b0a0908_0f0e0d0c_13121110_17161514_1b1a1918_1f1e1d1c;
    key_alt  = ~key_main;
    nonce_main = 96'h09000000_4a000000_00000000;
    rst_n = 1'b0; start = 1'b0; key = key_main; nonce = nonce_main;
    ctr_init = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // RFC 8439 2.3.2 keystream via zero plaintext
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back(32'h0);
    do_start(key_main, nonce_main, 32'd1);
    run_stream(16, 1, -1, 0, -1);
    for (int i = 0; i < 4; i++) chk("rfc_word", got[i], rfc[i]);
    check_msg("rfc_all", 32'd1);
    check_done();

    // Round trip over 40 words
    msg.delete(); orig.delete();
    for (int i = 0; i < 40; i++) msg.push_back($urandom);
    orig = msg;
    do_start(key_main, nonce_main, 32'd5);
    run_stream(40, 1, -1, 0, -1);
    check_msg("enc", 32'd5);
    chk("enc_bubbles", 32'(bubbles), 32'd4);
    chk("enc_ctr", dut.ctr, 32'd7);
    check_done();
    msg = got;
    do_start(key_main, nonce_main, 32'd5);
    run_stream(40, 1, -1, 0, -1);
    chk("dec_bubbles", 32'(bubbles), 32'd4);
    for (int i = 0; i < 40; i++) chk("dec_word", got[i], orig[i]);
    check_done();

    // Backpressure mid block
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back($urandom);
    do_start(key_main, nonce_main, 32'd9);
    run_stream(16, 1, 6, 5, -1);
    check_msg("bp", 32'd9);
    check_done();

    // Stray start with another key while streaming
    msg.delete();
    for (int i = 0; i < 20; i++) msg.push_back($urandom);
    do_start(key_main, nonce_main, 32'd3);
    run_stream(20, 1, -1, 0, 4);
    check_msg("stray", 32'd3);
    check_done();

    // Counter wrap
    msg.delete();
    for (int i = 0; i < 20; i++) msg.push_back(32'h0);
    do_start(key_main, nonce_main, 32'hffff_ffff);
    chk("wrap_clear_at_start", 32'(err_ctr_wrap), 32'd0);
    run_stream(20, 1, -1, 0, -1);
    check_msg("wrap", 32'hffff_ffff);
    chk("wrap_flag", 32'(err_ctr_wrap), 32'd1);
    check_done();
    chk("wrap_flag_idle", 32'(err_ctr_wrap), 32'd1);
    msg.delete();
    msg.push_back(32'h1234_5678);
    do_start(key_main, nonce_main, 32'd0);
    chk("wrap_flag_cleared", 32'(err_ctr_wrap), 32'd0);
    run_stream(1, 1, -1, 0, -1);
    check_msg("one_word", 32'd0);
    check_done();

    // Async reset at word 7
    msg.delete();
    for (int i = 0; i < 16; i++) msg.push_back($urandom);
    do_start(key_main, nonce_main, 32'd2);
    run_stream(7, 0, -1, 0, -1);
    in_valid = 1'b1; in_data = msg[7];
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 32'(out_valid), 32'd0);
    chk("ar_in_ready", 32'(in_ready), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_done", 32'(done), 32'd0);
    chk("ar_out_data", out_data, 32'd0);
    chk("ar_out_last", 32'(out_last), 32'd0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("ar_held_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(key_main, nonce_main, 32'd2);
    run_stream(16, 1, -1, 0, -1);
    check_msg("after_rst", 32'd2);
    check_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
